// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM over a shared ALU and one memory port
module multicycle_controller #(
    parameter int ALUCTL_W = 5,
    parameter int IMMSRC_W = 3,
    parameter bit WAIT_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [IMMSRC_W-1:0] imm_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [ALUCTL_W-1:0] ALU_ADD   = ALUCTL_W'(5'b00000);
    localparam logic [ALUCTL_W-1:0] ALU_SUB   = ALUCTL_W'(5'b00001);
    localparam logic [ALUCTL_W-1:0] ALU_AND   = ALUCTL_W'(5'b00010);
    localparam logic [ALUCTL_W-1:0] ALU_OR    = ALUCTL_W'(5'b00011);
    localparam logic [ALUCTL_W-1:0] ALU_XOR   = ALUCTL_W'(5'b00100);
    localparam logic [ALUCTL_W-1:0] ALU_SLT   = ALUCTL_W'(5'b00101);
    localparam logic [ALUCTL_W-1:0] ALU_SLL   = ALUCTL_W'(5'b00110);
    localparam logic [ALUCTL_W-1:0] ALU_SRL   = ALUCTL_W'(5'b00111);
    localparam logic [ALUCTL_W-1:0] ALU_PASSB = ALUCTL_W'(5'b10000);

    localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(3'b000);
    localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(3'b001);
    localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(3'b010);
    localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(3'b100);

    typedef struct packed {
        logic                adr_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                pc_write;
        logic [1:0]          result_src;
        logic [1:0]          alu_src_a;
        logic [1:0]          alu_src_b;
        logic [IMMSRC_W-1:0] imm_src;
        logic [ALUCTL_W-1:0] alu_control;
        logic                illegal;
    } ctrl_t;

    state_t state_q, state_d, state_n;
    ctrl_t  ctrl_q, ctrl_d;
    logic   ready;
    logic   is_load;
    logic   br_take;
    logic   fetch_go;
    logic   unused_funct7;

    assign ready         = WAIT_EN ? mem_ready : 1'b1;
    assign is_load       = (op == OP_LOAD);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // {funct7[5], funct3} selector shared by register and immediate ALU ops
    function automatic logic [ALUCTL_W-1:0] alu_lookup(input logic [3:0] key);
        case (key)
            4'b0000: return ALU_ADD;
            4'b1000: return ALU_SUB;
            4'b0111: return ALU_AND;
            4'b0110: return ALU_OR;
            4'b0100: return ALU_XOR;
            4'b0010: return ALU_SLT;
            4'b0001: return ALU_SLL;
            4'b0101: return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_TRAP;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    assign state_n = reset ? S_FETCH : state_d;

    // Moore outputs are decoded for the state being entered, so they register alongside it
    always_comb begin
        ctrl_d = '0;
        case (state_n)
            S_FETCH: begin
                ctrl_d.mem_read    = 1'b1;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.result_src  = 2'b10;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a   = 2'b01;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.imm_src     = IMM_B;
                ctrl_d.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a   = 2'b10;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.imm_src     = is_load ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.adr_src  = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b01;
            end
            S_MEMWRITE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.adr_src   = 1'b1;
            end
            S_EXECR: begin
                ctrl_d.alu_src_a   = 2'b10;
                ctrl_d.alu_control = alu_lookup({funct7[5], funct3});
            end
            S_EXECI: begin
                ctrl_d.alu_src_a   = 2'b10;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.imm_src     = IMM_I;
                ctrl_d.alu_control = alu_lookup({1'b0, funct3});
            end
            S_ALUWB: ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a   = 2'b10;
                ctrl_d.alu_control = ALU_SUB;
            end
            S_JAL: begin
                ctrl_d.alu_src_a   = 2'b01;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.pc_write    = 1'b1;
            end
            S_LUI: begin
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.imm_src     = IMM_U;
                ctrl_d.alu_control = ALU_PASSB;
            end
            S_TRAP:  ctrl_d.illegal = 1'b1;
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
        ctrl_q <= ctrl_d;
    end

    assign fetch_go = (state_q == S_FETCH) && ready;
    assign br_take  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    // Strobes are forced low while reset is held so an aborted instruction never writes
    assign pc_write    = !reset && (ctrl_q.pc_write || fetch_go || ((state_q == S_BRANCH) && br_take));
    assign ir_write    = !reset && fetch_go;
    assign mem_read    = !reset && ctrl_q.mem_read;
    assign mem_write   = !reset && ctrl_q.mem_write;
    assign reg_write   = !reset && ctrl_q.reg_write;
    assign adr_src     = ctrl_q.adr_src;
    assign result_src  = ctrl_q.result_src;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign imm_src     = ctrl_q.imm_src;
    assign alu_control = ctrl_q.alu_control;
    assign illegal     = ctrl_q.illegal;
    assign state_dbg   = state_q;

endmodule
